wisc_flag_unit: RTL and testbench
=================================

# wisc_flag_unit

- Holds the processor's N/Z/V condition flags.
- Flags are written from the saturating multifunction adder's result in EX.
- A branch in decode reads the flags and gets its 3-bit condition resolved to taken / not-taken.
- This block sits on the consumer side of the adder's result interface, between EX and the branch logic in ID.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX stage holds a real instruction
- ex_op  in  4  EX opcode: 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB, others non-ALU
- ex_s  in  16  final (saturated) ALU result
- ex_ovfl  in  1  adder signed-overflow indication (pre-saturation), ADD/SUB only
- stall  in  1  pipeline frozen; no flag update
- flush  in  1  EX instruction squashed; no flag update
- br_valid  in  1  decode holds a conditional branch
- br_ccc  in  3  branch condition code
- br_taken  out  1  branch resolves taken (combinational)
- br_stall  out  1  decode must hold the branch one cycle (combinational)
- flag_n, flag_z, flag_v  out  1 each  registered flags

## Operation
Flag write rules (wr = ex_valid & ~stall & ~flush):
- ADD/SUB: N ← ex_s[15], Z ← (ex_s == 0), V ← ex_ovfl.
- XOR/SLL/SRA/ROR: Z ← (ex_s == 0); N, V hold.
- RED, PADDSB, non-ALU: no flag change.
- Z reflects the saturated result: 0x7FFF or 0x8000 is never zero.

Effective flags (eN/eZ/eV):
- Without bypass: the registered flags.
- With bypass: the next-state values when wr is 1 and ex_op writes flags; the registered flags otherwise.

Condition codes, evaluated only when br_valid, else br_taken=0:
- 000 NE: ~eZ
- 001 EQ: eZ
- 010 GT: ~eZ & ~eN
- 011 LT: eN
- 100 GTE: eZ | (~eZ & ~eN)
- 101 LTE: eN | eZ
- 110 OVFL: eV
- 111 always taken

Hazard: a flag-writing op with ex_valid & ~flush meets br_valid in the same cycle. Resolution is per Configuration.

## Timing
- Reset: flag_n=0, flag_z=0, flag_v=0. br_taken and br_stall follow their inputs immediately (0 when br_valid=0).
- Flag update latency is 1 cycle: the write is visible on flag_* after the next rising edge.
- stall=1 holds all flags; br_taken is still evaluated on the current effective flags.
- flush=1 together with stall=1: no update; flush dominates the hazard check.
- An rst_n assertion mid-hazard clears the flags and br_stall immediately.
- Back-to-back flag writes: the last-cycle write wins; there is no accumulation.

## Configuration
FLAG_BYPASS_EN:
- Defined:
  - Bypass path active.
  - br_stall is tied 0.
  - br_taken uses the same-cycle EX result.
- Undefined:
  - No bypass; the hazard drives br_stall=1 and br_taken=0 that cycle.
  - The next cycle, EX is a bubble and the branch resolves on the updated registered flags.
  - br_stall never asserts for 2 consecutive cycles on one branch unless a new flag-writing op arrives in EX.

## Test plan
- Reset with rst_n=0 while ex_valid=1 and ADD ex_s=0 -> flags stay 000; after release, br_ccc=111 -> br_taken=1.
- ADD with ex_s=0x7FFF, ex_ovfl=1 -> next cycle N=0, Z=0, V=1; br_ccc=110 -> taken; br_ccc=001 -> not taken.
- SUB with ex_s=0x0000, ex_ovfl=0, then XOR with ex_s=0x8000 -> after SUB Z=1, N=0; after XOR Z=0 and N/V unchanged; br_ccc=100 taken after both.
- PADDSB with ex_s=0x0000 after flags N=1 -> flags unchanged (N=1, Z=0); br_ccc=011 -> taken.
- Hazard: ADD ex_s=0xFFFE with a simultaneous br_valid, br_ccc=011.
  - Without FLAG_BYPASS_EN: br_stall=1, br_taken=0; next cycle (ex_valid=0) br_taken=1, br_stall=0.
  - With FLAG_BYPASS_EN: br_taken=1 in the same cycle, br_stall=0.
- ADD ex_s=0 with flush=1, then with stall=1 -> Z unchanged both cycles; br_stall=0 in the flush cycle.

Source files
------------

// File: rtl/wisc_flag_unit.sv
// wisc_flag_unit
// Holds the N/Z/V condition flags written from the EX-stage ALU result and
// resolves a decode-stage branch condition against them.
// Optional feature: define FLAG_BYPASS_EN to forward the same-cycle EX flag
// write to the branch instead of stalling the branch for one cycle.
module wisc_flag_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic [15:0] ex_s,
    input  logic        ex_ovfl,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_valid,
    input  logic [2:0]  br_ccc,
    output logic        br_taken,
    output logic        br_stall,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_v
);

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111
    } alu_op_e;

    typedef enum logic [2:0] {
        CC_NE   = 3'b000,
        CC_EQ   = 3'b001,
        CC_GT   = 3'b010,
        CC_LT   = 3'b011,
        CC_GTE  = 3'b100,
        CC_LTE  = 3'b101,
        CC_OVFL = 3'b110,
        CC_ALW  = 3'b111
    } ccc_e;

    logic writes_nzv;   // ADD/SUB: all three flags
    logic writes_z;     // logic/shift ops: Z only
    logic flag_op;      // op touches at least one flag
    logic wr;           // EX result commits this cycle
    logic next_n, next_z, next_v;
    logic eff_n, eff_z, eff_v;
    logic cond_true;
    logic hazard;

    // Classify the EX opcode by which flags it writes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        writes_nzv = 1'b0;
        writes_z   = 1'b0;
        case (alu_op_e'(ex_op))
            OP_ADD, OP_SUB:                 writes_nzv = 1'b1;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: writes_z   = 1'b1;
            default:                        ;
        endcase
    end

    assign flag_op = writes_nzv | writes_z;
    assign wr      = ex_valid & ~stall & ~flush;

    // Next-state flags; Z looks at the saturated result, so 0x7FFF/0x8000 never read as zero.
    always_comb begin
        next_n = flag_n;
        next_z = flag_z;
        next_v = flag_v;
        if (wr && writes_nzv) begin
            next_n = ex_s[15];
            next_v = ex_ovfl;
        end
        if (wr && flag_op)
            next_z = (ex_s == 16'h0000);
    end

    // Flag register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flags update together at the edge.
        if (!rst_n) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            flag_n <= next_n;
            flag_z <= next_z;
            flag_v <= next_v;
        end
    end

    // A flag-writing op in EX meets a branch in decode; a flushed op cannot create a hazard.
    assign hazard = rst_n & br_valid & ex_valid & ~flush & flag_op;

`ifdef FLAG_BYPASS_EN
    // Forward the in-flight write so the branch resolves in the same cycle.
    always_comb begin
        eff_n = flag_n;
        eff_z = flag_z;
        eff_v = flag_v;
        if (rst_n && wr && flag_op) begin
            eff_n = next_n;
            eff_z = next_z;
            eff_v = next_v;
        end
    end

    assign br_stall = 1'b0;
`else
    // No forwarding: the branch sees only the registered flags.
    always_comb begin
        eff_n = flag_n;
        eff_z = flag_z;
        eff_v = flag_v;
    end

    // Holding the branch one cycle lets EX drain as a bubble and the flags settle.
    assign br_stall = hazard;
`endif

    // Evaluate the 3-bit branch condition on the effective flags.
    always_comb begin
        cond_true = 1'b0;
        case (ccc_e'(br_ccc))
            CC_NE:   cond_true = ~eff_z;
            CC_EQ:   cond_true = eff_z;
            CC_GT:   cond_true = ~eff_z & ~eff_n;
            CC_LT:   cond_true = eff_n;
            CC_GTE:  cond_true = eff_z | (~eff_z & ~eff_n);
            CC_LTE:  cond_true = eff_n | eff_z;
            CC_OVFL: cond_true = eff_v;
            CC_ALW:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign br_taken = br_valid & ~br_stall & cond_true;

endmodule

// File: tb/tb_wisc_flag_unit.sv
// Self-checking bench for wisc_flag_unit. Expected flags are produced by a
// small reference model and queued when EX stimulus is driven, then popped
// and compared one cycle later. Branch outcomes are checked inline.
module tb_wisc_flag_unit;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [15:0] ex_s;
    logic        ex_ovfl;
    logic        stall;
    logic        flush;
    logic        br_valid;
    logic [2:0]  br_ccc;
    logic        br_taken;
    logic        br_stall;
    logic        flag_n;
    logic        flag_z;
    logic        flag_v;

    int     checks = 0;
    int     errors = 0;
    flags_t model;
    flags_t exp_q[$];

    wisc_flag_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (ex_valid),
        .ex_op    (ex_op),
        .ex_s     (ex_s),
        .ex_ovfl  (ex_ovfl),
        .stall    (stall),
        .flush    (flush),
        .br_valid (br_valid),
        .br_ccc   (br_ccc),
        .br_taken (br_taken),
        .br_stall (br_stall),
        .flag_n   (flag_n),
        .flag_z   (flag_z),
        .flag_v   (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference next-state model of the flag write rules.
    function automatic flags_t model_next(flags_t cur, logic rst_ok, logic v, logic [3:0] op,
                                          logic [15:0] s, logic ov, logic stl, logic fl);
        flags_t nx = cur;
        logic   w  = v & ~stl & ~fl;
        if (!rst_ok) return '0;
        if (w && (op == 4'd0 || op == 4'd1)) begin
            nx.n = s[15];
            nx.v = ov;
            nx.z = (s == 16'h0000);
        end else if (w && (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6)) begin
            nx.z = (s == 16'h0000);
        end
        return nx;
    endfunction

    // Branch condition table on a given flag set.
    function automatic logic model_cond(flags_t f, logic [2:0] c);
        case (c)
            3'd0:    return ~f.z;
            3'd1:    return f.z;
            3'd2:    return ~f.z & ~f.n;
            3'd3:    return f.n;
            3'd4:    return f.z | (~f.z & ~f.n);
            3'd5:    return f.n | f.z;
            3'd6:    return f.v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic set_ex(logic v, logic [3:0] op, logic [15:0] s, logic ov);
        ex_valid = v;
        ex_op    = op;
        ex_s     = s;
        ex_ovfl  = ov;
    endtask

    task automatic set_br(logic v, logic [2:0] c);
        br_valid = v;
        br_ccc   = c;
    endtask

    // One clock: queue the expected flags for the current stimulus, then pop and compare after the edge.
    task automatic clock_cycle(string name);
        flags_t got;
        flags_t want;
        exp_q.push_back(model_next(model, rst_n, ex_valid, ex_op, ex_s, ex_ovfl, stall, flush));
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got  = {flag_n, flag_z, flag_v};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s flags nzv got %b expected %b", name, got, want);
        end
        model = want;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_br(1'b0, 3'd0);
        set_ex(1'b1, 4'd0, 16'h0000, 1'b0);
        model = '0;
        clock_cycle("reset_hold");
        clock_cycle("reset_hold2");
        rst_n = 1'b1;
        set_ex(1'b0, 4'd0, 16'h0000, 1'b0);
        set_br(1'b1, 3'b111);
        #1;
        checks++;
        if (br_taken !== 1'b1 || br_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_always taken %b stall %b expected 1 0", br_taken, br_stall);
        end
        set_br(1'b0, 3'd0);
        #1;
        checks++;
        if (br_taken !== 1'b0) begin
            errors++;
            $display("FAIL no_branch taken %b expected 0", br_taken);
        end
    endtask

    task automatic test_add_ovfl;
        set_ex(1'b1, 4'd0, 16'h7FFF, 1'b1);
        clock_cycle("add_sat_ovfl");
        set_ex(1'b0, 4'd0, 16'h0000, 1'b0);
        set_br(1'b1, 3'b110);
        #1;
        checks++;
        if (br_taken !== 1'b1) begin
            errors++;
            $display("FAIL ovfl_taken got %b expected 1", br_taken);
        end
        set_br(1'b1, 3'b001);
        #1;
        checks++;
        if (br_taken !== 1'b0) begin
            errors++;
            $display("FAIL eq_not_taken got %b expected 0", br_taken);
        end
        set_br(1'b0, 3'd0);
    endtask

    task automatic test_sub_xor;
        set_ex(1'b1, 4'd1, 16'h0000, 1'b0);
        clock_cycle("sub_zero");
        set_ex(1'b0, 4'd0, 16'h0000, 1'b0);
        set_br(1'b1, 3'b100);
        #1;
        checks++;
        if (br_taken !== 1'b1) begin
            errors++;
            $display("FAIL gte_after_sub got %b expected 1", br_taken);
        end
        set_br(1'b0, 3'd0);
        set_ex(1'b1, 4'd2, 16'h8000, 1'b1);
        clock_cycle("xor_z_only");
        set_ex(1'b0, 4'd0, 16'h0000, 1'b0);
        set_br(1'b1, 3'b100);
        #1;
        checks++;
        if (br_taken !== 1'b1) begin
            errors++;
            $display("FAIL gte_after_xor got %b expected 1", br_taken);
        end
        set_br(1'b0, 3'd0);
    endtask

    task automatic test_paddsb;
        set_ex(1'b1, 4'd0, 16'h8001, 1'b0);
        clock_cycle("add_negative");
        set_ex(1'b1, 4'd7, 16'h0000, 1'b1);
        clock_cycle("paddsb_hold");
        set_ex(1'b1, 4'd3, 16'h0000, 1'b1);
        clock_cycle("red_hold");
        set_ex(1'b1, 4'd9, 16'h0000, 1'b1);
        clock_cycle("nonalu_hold");
        set_ex(1'b0, 4'd0, 16'h0000, 1'b0);
        set_br(1'b1, 3'b011);
        #1;
        checks++;
        if (br_taken !== 1'b1) begin
            errors++;
            $display("FAIL lt_after_paddsb got %b expected 1", br_taken);
        end
        set_br(1'b0, 3'd0);
    endtask

    task automatic test_hazard;
        set_ex(1'b1, 4'd0, 16'h0001, 1'b0);
        clock_cycle("add_positive");
        set_ex(1'b1, 4'd0, 16'hFFFE, 1'b0);
        set_br(1'b1, 3'b011);
        #1;
        checks++;
`ifdef FLAG_BYPASS_EN
        if (br_taken !== 1'b1 || br_stall !== 1'b0) begin
            errors++;
            $display("FAIL hazard_bypass taken %b stall %b expected 1 0", br_taken, br_stall);
        end
`else
        if (br_taken !== 1'b0 || br_stall !== 1'b1) begin
            errors++;
            $display("FAIL hazard_stall taken %b stall %b expected 0 1", br_taken, br_stall);
        end
`endif
        clock_cycle("hazard_write");
        set_ex(1'b0, 4'd0, 16'h0000, 1'b0);
        #1;
        checks++;
        if (br_taken !== 1'b1 || br_stall !== 1'b0) begin
            errors++;
            $display("FAIL hazard_resolve taken %b stall %b expected 1 0", br_taken, br_stall);
        end
        set_br(1'b0, 3'd0);
    endtask

    task automatic test_flush_stall;
        set_ex(1'b1, 4'd0, 16'h0000, 1'b0);
        flush = 1'b1;
        set_br(1'b1, 3'b001);
        #1;
        checks++;
        if (br_stall !== 1'b0 || br_taken !== model_cond(model, 3'b001)) begin
            errors++;
            $display("FAIL flush_branch stall %b taken %b expected 0 %b",
                     br_stall, br_taken, model_cond(model, 3'b001));
        end
        clock_cycle("flush_no_write");
        set_br(1'b0, 3'd0);
        flush = 1'b0;
        stall = 1'b1;
        clock_cycle("stall_no_write");
        flush = 1'b1;
        clock_cycle("stall_flush_no_write");
        stall = 1'b0;
        flush = 1'b0;
        set_ex(1'b0, 4'd0, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back;
        set_ex(1'b1, 4'd0, 16'h0000, 1'b0);
        clock_cycle("b2b_first");
        set_ex(1'b1, 4'd1, 16'h8000, 1'b1);
        clock_cycle("b2b_second");
        for (int i = 0; i < 24; i++) begin
            set_ex(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                   ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom), 1'($urandom_range(0, 1)));
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 4) == 0);
            clock_cycle("random_write");
        end
        stall = 1'b0;
        flush = 1'b0;
        set_ex(1'b0, 4'd0, 16'h0000, 1'b0);
    endtask

    // Sweep every condition code against the flags the model currently holds.
    task automatic test_conditions(string name);
        for (int c = 0; c < 8; c++) begin
            set_br(1'b1, 3'(c));
            #1;
            checks++;
            if (br_taken !== model_cond(model, 3'(c))) begin
                errors++;
                $display("FAIL %s ccc %0d flags %b taken %b expected %b",
                         name, c, model, br_taken, model_cond(model, 3'(c)));
            end
        end
        set_br(1'b0, 3'd0);
    endtask

    task automatic test_reset_mid_hazard;
        set_ex(1'b1, 4'd1, 16'h8000, 1'b1);
        clock_cycle("pre_reset_set");
        set_ex(1'b1, 4'd0, 16'hFFFF, 1'b1);
        set_br(1'b1, 3'b011);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({flag_n, flag_z, flag_v} !== 3'b000 || br_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hazard flags %b stall %b expected 000 0",
                     {flag_n, flag_z, flag_v}, br_stall);
        end
        model = '0;
        set_br(1'b0, 3'd0);
        set_ex(1'b0, 4'd0, 16'h0000, 1'b0);
        clock_cycle("reset_after_hazard");
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add_ovfl();
        test_conditions("cond_nzv_001");
        test_sub_xor();
        test_paddsb();
        test_conditions("cond_nzv_100");
        test_hazard();
        test_flush_stall();
        test_back_to_back();
        test_conditions("cond_random");
        test_reset_mid_hazard();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout reached time %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
